// File: rtl/mips_defs.sv
// Shared definitions for the MIPS instruction-memory boot path.
package mips_defs;
  localparam int IM_ADDR_W = 10;
  localparam int IM_DEPTH  = 1024;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } ld_state_e;
endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into big-endian 32-bit words; word_full flags the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx  <= '0;
      word <= '0;
    end else if (shift_en) begin
      idx  <= idx + 2'd1;
      word <= {word[23:0], byte_in};
    end
  end

  assign word_full = shift_en && (idx == 2'd3);
endmodule

// File: rtl/im_boot_loader.sv
// Streams a length-prefixed program image into instruction memory and holds
// the CPU in reset until the whole image has been written.
module im_boot_loader
  import mips_defs::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DEPTH  = IM_DEPTH,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam logic [31:0] CAP = 32'(DEPTH - BASE);

  ld_state_e         state, state_nx;
  logic              armed;
  logic [15:0]       n_words;
  logic [15:0]       n_full;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wcnt;
  logic              xfer;
  logic              word_full;
  logic              pk_clear;
  logic              pk_shift;

  assign xfer   = in_valid && in_ready;
  assign n_full = {n_words[15:8], in_data};

  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (in_data),
    .word      (im_wdata),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HDR_HI;
      armed   <= 1'b0;
      n_words <= '0;
      waddr   <= ADDR_W'(BASE);
      wcnt    <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (xfer && state == HDR_HI) n_words[15:8] <= in_data;
      if (xfer && state == HDR_LO) n_words[7:0]  <= in_data;
      if (state == WRITE) begin
        waddr <= waddr + ADDR_W'(1);
        wcnt  <= wcnt + (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    im_we    = 1'b0;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      HDR_HI: begin
        // armed keeps in_ready low for the first cycle out of reset
        in_ready = armed;
        pk_clear = 1'b1;
        if (xfer) state_nx = HDR_LO;
      end
      HDR_LO: begin
        in_ready = armed;
        if (xfer) begin
          if ({16'd0, n_full} > CAP) state_nx = ERR;
          else if (n_full == 16'd0)  state_nx = DONE;
          else                       state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = armed;
        pk_shift = xfer;
        if (word_full) state_nx = WRITE;
      end
      WRITE: begin
        im_we = 1'b1;
        if ({{(31-ADDR_W){1'b0}}, wcnt} + 32'd1 == {16'd0, n_words}) state_nx = DONE;
        else                                                        state_nx = DATA;
      end
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ERR: err = 1'b1;
      default: state_nx = HDR_HI;
    endcase
  end

  assign im_waddr     = waddr;
  assign words_loaded = wcnt;
endmodule

// File: tb/tb_im_boot_loader.sv
// Randomized self-checking bench for im_boot_loader against a stream-level model.
module tb_im_boot_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int BASE   = 0;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, im_we, cpu_rst, done, err;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   words_loaded;

  im_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int we_bad = 0;
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (im_we) begin
      cap_addr.push_back(im_waddr);
      cap_data.push_back(im_wdata);
      if (in_ready) we_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_im_we"}, im_we, 0);
    chk({pfx, "_im_waddr"}, im_waddr, BASE);
    chk({pfx, "_im_wdata"}, im_wdata, 0);
    chk({pfx, "_cpu_rst"}, cpu_rst, 1);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_words_loaded"}, words_loaded, 0);
  endtask

  // mode 0: valid always high, 1: valid every other cycle, 2: random valid
  task automatic drive(input bq_t s, input int n_send, input int mode,
                       output int first, output int sent);
    int budget;
    int ph;
    bit fire;
    budget = 8 * n_send + 40;
    ph = 0;
    first = -1;
    sent = 0;
    while (sent < n_send && budget > 0) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (ph % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_data = in_valid ? s[sent] : 8'($urandom);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        if (first < 0) first = cyc;
        sent++;
      end
      ph++;
      budget--;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic run_load(input bq_t s, input int mode, input bit timing);
    int n, n_acc, first, sent, k, base_cnt, exp_wr;
    bit oversize;
    n = int'({s[0], s[1]});
    oversize = n > DEPTH - BASE;
    exp_wr = oversize ? 0 : n;
    n_acc = 2 + 4 * exp_wr;
    base_cnt = cap_data.size();
    drive(s, n_acc, mode, first, sent);
    chk("bytes_accepted", sent, n_acc);
    k = 0;
    while (!(done || err) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (timing && !oversize) chk("load_cycles", cyc - first + 1, 2 + 5 * n);
    chk("done", done, !oversize);
    chk("err", err, oversize);
    chk("cpu_rst", cpu_rst, oversize);
    chk("in_ready_end", in_ready, 0);
    chk("words_loaded", words_loaded, exp_wr);
    chk("waddr_end", im_waddr, BASE + exp_wr);
    chk("n_writes", cap_data.size() - base_cnt, exp_wr);
    for (int i = 0; i < exp_wr && base_cnt + i < cap_data.size(); i++) begin
      chk("wr_addr", cap_addr[base_cnt + i], BASE + i);
      chk("wr_data", cap_data[base_cnt + i], {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
    end
    chk("we_while_ready", we_bad, 0);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bq_t basic, s;
    int first, sent, sz, n;
    logic [ADDR_W:0] wl;
    basic = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};

    // Reset values, then in_ready rises one cycle after rst is released
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    chk("ready_low_at_release", in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_release", in_ready, 1);

    run_load(basic, 0, 1);

    // Stream after done must be refused
    sz = cap_data.size();
    wl = words_loaded;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      chk("post_done_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("post_done_writes", cap_data.size() - sz, 0);
    chk("post_done_done", done, 1);
    chk("post_done_wl", words_loaded, wl);

    reset_cycle();
    run_load(basic, 1, 0);

    reset_cycle();
    s = '{8'h00, 8'h00};
    run_load(s, 0, 1);

    reset_cycle();
    s = '{8'h04, 8'h01};
    run_load(s, 0, 0);
    reset_cycle();
    s = '{8'hFF, 8'hFF};
    run_load(s, 2, 0);

    // Reset in the middle of word 1
    reset_cycle();
    sz = cap_data.size();
    drive(basic, 8, 0, first, sent);
    chk("mid_sent", sent, 8);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    chk("mid_writes_before", cap_data.size() - sz, 1);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    run_load(basic, 0, 1);

    // Randomized images, occasionally oversize
    for (int it = 0; it < 8; it++) begin
      reset_cycle();
      s = {};
      if ($urandom_range(0, 4) == 0) n = $urandom_range(DEPTH - BASE + 1, 65535);
      else n = $urandom_range(0, 6);
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n <= DEPTH - BASE)
        for (int b = 0; b < 4 * n; b++) s.push_back(8'($urandom));
      run_load(s, (it % 3 == 0) ? 0 : 2, (it % 3 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
